// File: rtl/tlm_collect_pkg.sv
// Shared types for the TLM stimulus/result path: packet layout, bank states,
// and the width helper for item counts.
package tlm_collect_pkg;

   localparam int DEF_NUM        = 100;
   localparam int DEF_ITEM_WIDTH = 16;
   localparam int DEF_RES_WIDTH  = 8;

   typedef logic [DEF_ITEM_WIDTH-1:0]              item_t;
   typedef logic [DEF_NUM-1:0][DEF_ITEM_WIDTH-1:0] pkt_t;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_state_e;

   // Width able to hold 0..n inclusive.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tlm_result_collector_if.sv
// Result-capture and packet-drain signals of the collector, bundled with
// master (BFM/software side) and slave (collector side) views.
interface tlm_result_collector_if
   import tlm_collect_pkg::*;
#(
   parameter int NUM        = 100,
   parameter int ITEM_WIDTH = 16,
   parameter int RES_WIDTH  = 8
) ();

   localparam int CW = count_width(NUM);

   logic                             res_valid_i;
   logic [RES_WIDTH-1:0]             res_i;
   logic                             res_ready_o;
   logic                             flush_i;
   logic                             pkt_valid_o;
   logic                             pkt_ready_i;
   logic [NUM-1:0][ITEM_WIDTH-1:0]   pkt_data_o;
   logic [CW-1:0]                    pkt_count_o;
   logic [15:0]                      pkt_seq_o;
   logic                             overflow_o;

   modport master (
      output res_valid_i, res_i, flush_i, pkt_ready_i,
      input  res_ready_o, pkt_valid_o, pkt_data_o, pkt_count_o, pkt_seq_o, overflow_o
   );

   modport slave (
      input  res_valid_i, res_i, flush_i, pkt_ready_i,
      output res_ready_o, pkt_valid_o, pkt_data_o, pkt_count_o, pkt_seq_o, overflow_o
   );

endinterface

// File: rtl/collect_bank.sv
// One packet buffer of the ping-pong pair: item storage, fill state and the
// item count latched when the packet is closed.
module collect_bank
   import tlm_collect_pkg::*;
#(
   parameter int NUM        = 100,
   parameter int ITEM_WIDTH = 16,
   parameter int IW         = $clog2(NUM),
   parameter int CW         = count_width(NUM)
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           we_i,
   input  logic [IW-1:0]                  idx_i,
   input  logic [ITEM_WIDTH-1:0]          data_i,
   input  logic                           close_i,
   input  logic [CW-1:0]                  count_i,
   input  logic                           drain_i,
   output bank_state_e                    state_o,
   output logic [CW-1:0]                  count_o,
   output logic [NUM-1:0][ITEM_WIDTH-1:0] data_o
);

   logic [ITEM_WIDTH-1:0] mem_reg [NUM];
   bank_state_e           state_reg;
   logic [CW-1:0]         count_reg;

   // Storage is never reset; stale items are masked by the latched count.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_reg[idx_i] <= data_i;
      end
   end

   // Drain and close never target the same bank in one cycle.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg <= EMPTY;
         count_reg <= '0;
      end else if (drain_i) begin
         state_reg <= EMPTY;
      end else if (close_i) begin
         state_reg <= FULL;
         count_reg <= count_i;
      end else if (we_i && state_reg == EMPTY) begin
         state_reg <= FILLING;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_item
         assign data_o[gi] = mem_reg[gi];
      end
   endgenerate

   assign state_o = state_reg;
   assign count_o = count_reg;

endmodule

// File: rtl/tlm_result_collector.sv
// Ping-pong result collector: packs BFM results into NUM-item packets and
// hands them out over a valid/ready port while the other bank keeps filling.
module tlm_result_collector
   import tlm_collect_pkg::*;
#(
   parameter int NUM        = 100,
   parameter int ITEM_WIDTH = 16,
   parameter int RES_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   tlm_result_collector_if.slave bus
);

   localparam int CW = count_width(NUM);
   localparam int IW = $clog2(NUM);

   logic          fill_bank_reg;
   logic          out_bank_reg;
   logic [IW-1:0] wr_idx_reg;
   logic          overflow_reg;
   logic [15:0]   seq_reg;

   bank_state_e                    bank_state [2];
   logic [CW-1:0]                  bank_count [2];
   logic [NUM-1:0][ITEM_WIDTH-1:0] bank_data  [2];
   logic [1:0]                     bank_full;
   logic [1:0]                     bank_we;
   logic [1:0]                     bank_close;
   logic [1:0]                     bank_drain;

   logic                  res_ready;
   logic                  accept;
   logic                  last_item;
   logic                  close_fill;
   logic                  transfer;
   logic [CW-1:0]         close_count;
   logic [ITEM_WIDTH-1:0] wr_data;

   assign res_ready   = !bank_full[fill_bank_reg];
   assign accept      = bus.res_valid_i && res_ready;
   assign last_item   = accept && (wr_idx_reg == IW'(NUM - 1));
   // A flush only closes a bank that holds or is receiving at least one item.
   assign close_fill  = last_item ||
                        (bus.flush_i && res_ready && (wr_idx_reg != '0 || accept));
   assign close_count = CW'(wr_idx_reg) + CW'(accept);
   assign transfer    = bank_full[out_bank_reg] && bus.pkt_ready_i;
   assign wr_data     = ITEM_WIDTH'(bus.res_i);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         assign bank_full[gi]  = (bank_state[gi] == FULL);
         assign bank_we[gi]    = accept     && (fill_bank_reg == 1'(gi));
         assign bank_close[gi] = close_fill && (fill_bank_reg == 1'(gi));
         assign bank_drain[gi] = transfer   && (out_bank_reg  == 1'(gi));

         collect_bank #(
            .NUM        (NUM),
            .ITEM_WIDTH (ITEM_WIDTH),
            .IW         (IW),
            .CW         (CW)
         ) u_bank (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .we_i      (bank_we[gi]),
            .idx_i     (wr_idx_reg),
            .data_i    (wr_data),
            .close_i   (bank_close[gi]),
            .count_i   (close_count),
            .drain_i   (bank_drain[gi]),
            .state_o   (bank_state[gi]),
            .count_o   (bank_count[gi]),
            .data_o    (bank_data[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fill_bank_reg <= 1'b0;
         out_bank_reg  <= 1'b0;
         wr_idx_reg    <= '0;
         overflow_reg  <= 1'b0;
         seq_reg       <= '0;
      end else begin
         if (close_fill) begin
            fill_bank_reg <= ~fill_bank_reg;
            wr_idx_reg    <= '0;
         end else if (accept) begin
            wr_idx_reg    <= wr_idx_reg + IW'(1);
         end
         if (transfer) begin
            out_bank_reg  <= ~out_bank_reg;
            seq_reg       <= seq_reg + 16'd1;
         end
         if (bus.res_valid_i && !res_ready) begin
            overflow_reg  <= 1'b1;
         end
      end
   end

   assign bus.res_ready_o = res_ready;
   assign bus.pkt_valid_o = bank_full[out_bank_reg];
   assign bus.pkt_data_o  = bank_data[out_bank_reg];
   assign bus.pkt_count_o = bank_full[out_bank_reg] ? bank_count[out_bank_reg] : '0;
   assign bus.pkt_seq_o   = seq_reg;
   assign bus.overflow_o  = overflow_reg;

endmodule

// File: tb/tb_tlm_result_collector.sv
// Directed and random stimulus for tlm_result_collector, checked against a
// packet-queue reference model.
module tb_tlm_result_collector;

   localparam int NUM = 4;
   localparam int IW  = 16;
   localparam int RW  = 8;

   typedef struct {
      logic [NUM-1:0][IW-1:0] items;
      int                     cnt;
   } pkt_s;

   logic clk_i     = 1'b0;
   logic reset_n_i = 1'b0;

   always #5 clk_i = ~clk_i;

   tlm_result_collector_if #(.NUM(NUM), .ITEM_WIDTH(IW), .RES_WIDTH(RW)) bus ();

   tlm_result_collector #(.NUM(NUM), .ITEM_WIDTH(IW), .RES_WIDTH(RW)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   pkt_s        pend[$];
   logic [15:0] part[$];
   logic [15:0] m_seq;
   logic        m_ovf;
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      part.delete();
      m_seq = '0;
      m_ovf = 1'b0;
   endtask

   task automatic check_outputs();
      chk("res_ready", 32'(bus.res_ready_o), 32'(pend.size() < 2));
      chk("pkt_valid", 32'(bus.pkt_valid_o), 32'(pend.size() > 0));
      chk("pkt_seq",   32'(bus.pkt_seq_o),   32'(m_seq));
      chk("overflow",  32'(bus.overflow_o),  32'(m_ovf));
      if (pend.size() > 0) begin
         chk("pkt_count", 32'(bus.pkt_count_o), 32'(pend[0].cnt));
         for (int k = 0; k < pend[0].cnt; k++) begin
            chk($sformatf("item%0d", k), 32'(bus.pkt_data_o[k]), 32'(pend[0].items[k]));
         end
      end
   endtask

   // One clock: drive, check pre-edge outputs, then advance the model by the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
      bit   rdy, acc, xfer, close;
      pkt_s p;
      @(negedge clk_i);
      bus.res_valid_i = v;
      bus.res_i       = d;
      bus.flush_i     = f;
      bus.pkt_ready_i = r;
      #1;
      check_outputs();
      rdy  = (pend.size() < 2);
      acc  = v && rdy;
      xfer = (pend.size() > 0) && r;
      if (v && !rdy) m_ovf = 1'b1;
      if (xfer) begin
         void'(pend.pop_front());
         m_seq = m_seq + 16'd1;
      end
      if (acc) part.push_back(16'(d));
      close = (acc && part.size() == NUM) || (f && rdy && part.size() > 0);
      if (close) begin
         p.items = '0;
         p.cnt   = part.size();
         for (int k = 0; k < part.size(); k++) p.items[k] = part[k];
         pend.push_back(p);
         part.delete();
      end
   endtask

   initial begin
      bus.res_valid_i = 1'b0;
      bus.res_i       = '0;
      bus.flush_i     = 1'b0;
      bus.pkt_ready_i = 1'b0;
      model_reset();

      // Reset values while held in reset
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_ready", 32'(bus.res_ready_o), 32'd1);
      chk("rst_valid", 32'(bus.pkt_valid_o), 32'd0);
      chk("rst_count", 32'(bus.pkt_count_o), 32'd0);
      chk("rst_seq",   32'(bus.pkt_seq_o),   32'd0);
      chk("rst_ovf",   32'(bus.overflow_o),  32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // Basic packet with consumer ready
      step(1, 8'h11, 0, 1);
      step(1, 8'h22, 0, 1);
      step(1, 8'h33, 0, 1);
      step(1, 8'h44, 0, 1);
      step(0, 8'h00, 0, 1);
      chk("s1_data", 32'(bus.pkt_data_o[3]), 32'h0044);
      chk("s1_cnt",  32'(bus.pkt_count_o),   32'd4);
      step(0, 8'h00, 0, 1);
      chk("s1_seq",  32'(bus.pkt_seq_o),     32'd1);

      // 12 back-to-back results, consumer always ready
      for (int i = 0; i < 12; i++) step(1, 8'(8'h80 + i), 0, 1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      chk("s2_seq", 32'(bus.pkt_seq_o),  32'd4);
      chk("s2_ovf", 32'(bus.overflow_o), 32'd0);

      // Consumer stalled: both banks fill, 9th result dropped
      for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0, 0);
      step(0, 8'h00, 0, 0);
      chk("s3_ovf",   32'(bus.overflow_o),  32'd1);
      chk("s3_ready", 32'(bus.res_ready_o), 32'd0);
      chk("s3_item0", 32'(bus.pkt_data_o[0]), 32'h00C0);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("s3_seq", 32'(bus.pkt_seq_o), 32'd6);

      // Partial packet closed by flush; flush on empty bank ignored
      step(1, 8'hA5, 0, 0);
      step(1, 8'h5A, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      chk("s4_count", 32'(bus.pkt_count_o),   32'd2);
      chk("s4_item1", 32'(bus.pkt_data_o[1]), 32'h005A);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("s4_noflushpkt", 32'(bus.pkt_valid_o), 32'd0);

      // Drain coincides with completion of the other bank
      for (int i = 0; i < 7; i++) step(1, 8'(8'h30 + i), 0, 0);
      step(1, 8'h37, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("s5_ready", 32'(bus.res_ready_o), 32'd1);
      chk("s5_valid", 32'(bus.pkt_valid_o), 32'd1);
      chk("s5_item3", 32'(bus.pkt_data_o[3]), 32'h0037);
      step(0, 8'h00, 0, 1);

      // Asynchronous reset mid-packet
      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      @(negedge clk_i);
      bus.res_valid_i = 1'b1;
      bus.res_i       = 8'hEE;
      reset_n_i       = 1'b0;
      #1;
      chk("mrst_ready", 32'(bus.res_ready_o), 32'd1);
      chk("mrst_valid", 32'(bus.pkt_valid_o), 32'd0);
      chk("mrst_count", 32'(bus.pkt_count_o), 32'd0);
      chk("mrst_seq",   32'(bus.pkt_seq_o),   32'd0);
      chk("mrst_ovf",   32'(bus.overflow_o),  32'd0);
      @(negedge clk_i);
      bus.res_valid_i = 1'b0;
      reset_n_i       = 1'b1;
      model_reset();
      step(1, 8'h61, 0, 1);
      step(1, 8'h62, 0, 1);
      step(1, 8'h63, 0, 1);
      step(1, 8'h64, 0, 1);
      step(0, 8'h00, 0, 1);
      chk("mrst_item0", 32'(bus.pkt_data_o[0]), 32'h0061);
      step(0, 8'h00, 0, 0);
      chk("mrst_seq1", 32'(bus.pkt_seq_o), 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
